// File: rtl/key_bounce_gen.sv
// Emulates a mechanical push-button: bouncing falling edge, timed hold, bouncing rising edge, settle.
// Bounce segment lengths come from a free-running LFSR; all outputs are registered.
module key_bounce_gen #(
  parameter logic [19:0] TICK_DIV    = 20'd999_999,
  parameter int          BOUNCE_N    = 6,
  parameter logic [11:0] BOUNCE_MASK = 12'hFFF,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] press_ticks,
  output logic       key,
  output logic       busy,
  output logic       done,
  output logic [7:0] press_cnt
);

  typedef enum logic [2:0] {IDLE, FALL_BOUNCE, HOLD, RISE_BOUNCE, SETTLE} state_t;

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [7:0]  BN       = BOUNCE_N[7:0];

  state_t      state_q;
  logic [15:0] lfsr_q, lfsr_d;
  logic [12:0] seg_q, seg_d;
  logic [19:0] div_q;
  logic [7:0]  tcnt_q;
  logic [7:0]  ticks_q;
  logic [7:0]  bcnt_q;
  logic        key_q, busy_q, done_q;
  logic [7:0]  cnt_q;

  // x^16+x^14+x^13+x^11+1, shifting toward bit 0
  always_comb begin
    lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    seg_d  = {1'b0, lfsr_q[11:0] & BOUNCE_MASK} + 13'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      lfsr_q  <= SEED_EFF;
      seg_q   <= '0;
      div_q   <= '0;
      tcnt_q  <= '0;
      ticks_q <= '0;
      bcnt_q  <= '0;
      key_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            ticks_q <= (press_ticks == 8'd0) ? 8'd1 : press_ticks;
            bcnt_q  <= BN;
            seg_q   <= seg_d;
            key_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= FALL_BOUNCE;
          end
        end
        FALL_BOUNCE, RISE_BOUNCE: begin
          if (seg_q == 13'd1) begin
            if (bcnt_q != 8'd0) begin
              key_q  <= ~key_q;
              bcnt_q <= bcnt_q - 8'd1;
              seg_q  <= seg_d;
            end else begin
              // even toggle count leaves key already at the phase's final level
              div_q   <= '0;
              tcnt_q  <= '0;
              state_q <= (state_q == FALL_BOUNCE) ? HOLD : SETTLE;
            end
          end else begin
            seg_q <= seg_q - 13'd1;
          end
        end
        HOLD: begin
          if (div_q == TICK_DIV) begin
            div_q <= '0;
            if (tcnt_q == ticks_q - 8'd1) begin
              key_q   <= 1'b1;
              bcnt_q  <= BN;
              seg_q   <= seg_d;
              state_q <= RISE_BOUNCE;
            end else begin
              tcnt_q <= tcnt_q + 8'd1;
            end
          end else begin
            div_q <= div_q + 20'd1;
          end
        end
        SETTLE: begin
          if (div_q == TICK_DIV) begin
            div_q <= '0;
            if (tcnt_q == 8'd1) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              cnt_q   <= cnt_q + 8'd1;
              state_q <= IDLE;
            end else begin
              tcnt_q <= tcnt_q + 8'd1;
            end
          end else begin
            div_q <= div_q + 20'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign key       = key_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign press_cnt = cnt_q;

endmodule

// File: tb/tb_key_bounce_gen.sv
// Directed bench for key_bounce_gen: run lengths of key are predicted from an LFSR model of the polynomial.
module tb_key_bounce_gen;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] press_ticks;
  logic       key;
  logic       busy;
  logic       done;
  logic [7:0] press_cnt;

  key_bounce_gen #(
    .TICK_DIV(20'd9),
    .BOUNCE_N(4),
    .BOUNCE_MASK(12'h003),
    .SEED(16'hACE1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .press_ticks(press_ticks),
    .key(key),
    .busy(busy),
    .done(done),
    .press_cnt(press_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference LFSR, x^16+x^14+x^13+x^11+1
  logic [15:0] lfsr_m;
  always @(posedge clk or negedge rst) begin
    if (!rst) lfsr_m <= 16'hACE1;
    else      lfsr_m <= {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
  end

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  exp_cnt = 8'd0;
  logic [15:0] launch_lf;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // call at a negedge in IDLE; returns at the negedge right after the start edge
  task automatic launch(input logic [7:0] t);
    start       = 1'b1;
    press_ticks = t;
    launch_lf   = lfsr_m;
    @(negedge clk);
    start = 1'b0;
  endtask

  // samples one press from its first cycle to the done cycle, checking every run of key
  task automatic measure(input int hold_exp, input string nm, input bit glitch,
                         input bit chain, input logic [7:0] t2);
    int          len [16];
    logic [15:0] lf  [16];
    int          nrun;
    int          nb_busy;
    int          expl;
    logic        lvl;
    logic [15:0] prev;
    bit          got;
    nrun = 0; nb_busy = 0; lvl = 1'b1; prev = launch_lf; got = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (busy !== 1'b1) nb_busy++;
      if (key !== lvl) begin
        lvl = key;
        if (nrun < 16) begin
          len[nrun] = 1;
          lf[nrun]  = prev;
        end
        nrun++;
      end else if (nrun > 0 && nrun <= 16) begin
        len[nrun-1]++;
      end
      // a second start well inside HOLD must be ignored
      if (glitch && nrun == 5 && len[4] == 8) begin
        start = 1'b1;
        press_ticks = 8'd7;
      end else begin
        start = 1'b0;
      end
      prev = lfsr_m;
      @(negedge clk);
    end
    start = 1'b0;
    check({nm, "_done_seen"}, 32'(got), 32'd1);
    check({nm, "_runs"}, nrun, 10);
    for (int k = 0; k < 10 && k < nrun; k++) begin
      expl = int'(lf[k][1:0]) + 1 + ((k == 4) ? hold_exp : 0) + ((k == 9) ? 20 : 0);
      check($sformatf("%s_run%0d", nm, k), len[k], expl);
    end
    check({nm, "_busy_low"}, nb_busy, 0);
    exp_cnt = exp_cnt + 8'd1;
    check({nm, "_cnt"}, press_cnt, exp_cnt);
    check({nm, "_key_idle"}, key, 1'b1);
    check({nm, "_busy_idle"}, busy, 1'b0);
    if (chain) begin
      start       = 1'b1;
      press_ticks = t2;
      launch_lf   = lfsr_m;
    end
    @(negedge clk);
    start = 1'b0;
    check({nm, "_done_once"}, done, 1'b0);
  endtask

  typedef struct {
    logic [7:0] ticks;
    int         hold;
    bit         glitch;
    bit         chain;
    logic [7:0] ticks2;
    int         hold2;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'd3, 30, 1'b0, 1'b0, 8'd0, 0};
    vecs[1] = '{8'd0, 10, 1'b0, 1'b0, 8'd0, 0};
    vecs[2] = '{8'd1, 10, 1'b0, 1'b0, 8'd0, 0};
    vecs[3] = '{8'd2, 20, 1'b1, 1'b0, 8'd0, 0};
    vecs[4] = '{8'd5, 50, 1'b0, 1'b1, 8'd1, 10};

    rst = 1'b0; start = 1'b0; press_ticks = 8'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_key", key, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_cnt", press_cnt, 8'd0);
    end
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      launch(vecs[i].ticks);
      measure(vecs[i].hold, $sformatf("v%0d", i), vecs[i].glitch, vecs[i].chain, vecs[i].ticks2);
      if (vecs[i].chain) measure(vecs[i].hold2, $sformatf("v%0d_b", i), 1'b0, 1'b0, 8'd0);
      repeat (2) @(negedge clk);
    end

    // reset in the middle of HOLD: 25 cycles is past the fall bounce and short of hold end
    launch(8'd3);
    repeat (24) @(negedge clk);
    check("hold_key_low", key, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("arst_key", key, 1'b1);
    check("arst_busy", busy, 1'b0);
    check("arst_cnt", press_cnt, 8'd0);
    exp_cnt = 8'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("arst_no_done", done, 1'b0);
    end
    rst = 1'b1;
    launch(8'd0);
    for (int i = 0; i < 256; i++) begin
      measure(10, "wrap", 1'b0, (i < 255), 8'd0);
    end
    check("wrap_cnt_zero", press_cnt, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
